// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit scheduler: FSM encoding, IPv4 header
// constants and the one's-complement fold used for the header checksum.
package udp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_CSUM,
        ST_START,
        ST_SEND,
        ST_FIN
    } state_e;

    localparam logic [15:0] IP_VER_IHL          = 16'h4500;
    localparam logic [15:0] IP_FLAGS_DF         = 16'h4000;
    localparam logic [7:0]  IP_PROTO_UDP        = 8'h11;
    localparam logic [15:0] IP_UDP_OVERHEAD     = 16'd28;
    localparam int          DEFAULT_MAX_PAYLOAD = 1472;
    localparam int          CSUM_WORDS          = 9;

    // Two end-around-carry folds always suffice for a sum of nine 16-bit words.
    function automatic logic [15:0] csum_fold(input logic [19:0] sum);
        logic [19:0] f1;
        logic [19:0] f2;
        f1 = {4'b0, sum[15:0]} + {16'b0, sum[19:16]};
        f2 = {4'b0, f1[15:0]} + {16'b0, f1[19:16]};
        return 16'(f2);
    endfunction

endpackage

// File: rtl/udp_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i,
// wrapping modulo NUM_CH. Zero latency; no backpressure (pure function of inputs).
module udp_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int PW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PW-1:0]     ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [PW-1:0]     idx_o,
    output logic              vld_o
);

    always_comb begin
        int c;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        c     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(ptr_i) + i) % NUM_CH;
            if (!vld_o && req_i[c]) begin
                vld_o    = 1'b1;
                idx_o    = PW'(c);
                gnt_o[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Round-robin sequencer sharing one UDP/IP/MAC transmitter between NUM_CH sources;
// computes IP length/checksum, 12 cycles idle-to-start, payload flow follows tx_data_in_rd.
// Optional stall watchdog in SEND enabled by UDP_TX_WATCHDOG_EN.
module udp_tx_scheduler
    import udp_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int MAX_PAYLOAD = DEFAULT_MAX_PAYLOAD,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    req,
    input  logic [16*NUM_CH-1:0] ch_src_port,
    input  logic [16*NUM_CH-1:0] ch_dst_port,
    input  logic [16*NUM_CH-1:0] ch_len,
    input  logic [32*NUM_CH-1:0] ch_data,
    output logic [NUM_CH-1:0]    ch_data_rd,
    output logic [NUM_CH-1:0]    grant,
    output logic [NUM_CH-1:0]    done,
    output logic [NUM_CH-1:0]    err,
    input  logic [31:0]          cfg_ip_src,
    input  logic [31:0]          cfg_ip_dst,
    input  logic [7:0]           cfg_ttl,
    output logic                 tx_start,
    output logic [15:0]          tx_udp_src_port,
    output logic [15:0]          tx_udp_dst_port,
    output logic [15:0]          tx_udp_data_length,
    output logic [15:0]          tx_ip_total_len,
    output logic [15:0]          tx_ip_id,
    output logic [15:0]          tx_ip_head_chksum,
    output logic [31:0]          tx_data_in,
    input  logic                 tx_data_in_rd,
    input  logic                 tx_eop,
    output logic                 tx_abort,
    output logic                 busy
);

    localparam int PW = $clog2(NUM_CH);

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       k_q, k_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [15:0]         sport_q, sport_d;
    logic [15:0]         dport_q, dport_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         tot_q, tot_d;
    logic [15:0]         ip_id_q, ip_id_d;
    logic [15:0]         chk_q, chk_d;
    logic [19:0]         sum_q, sum_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [15:0]         csum_word;
    logic                wdog_fire;

    logic [NUM_CH-1:0]   arb_gnt;
    logic [PW-1:0]       arb_idx;
    logic                arb_vld;

    logic [15:0]         sport_a [NUM_CH];
    logic [15:0]         dport_a [NUM_CH];
    logic [15:0]         len_a   [NUM_CH];
    logic [31:0]         data_a  [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sport_a[i] = ch_src_port[16*i +: 16];
            dport_a[i] = ch_dst_port[16*i +: 16];
            len_a[i]   = ch_len[16*i +: 16];
            data_a[i]  = ch_data[32*i +: 32];
        end
    end

    udp_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PW     (PW)
    ) u_arb (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .vld_o  (arb_vld)
    );

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] idx);
        return (idx == PW'(NUM_CH - 1)) ? '0 : idx + PW'(1);
    endfunction

    // Header words in the order they are summed, one per CSUM cycle.
    always_comb begin
        case (cnt_q)
            4'd0:    csum_word = IP_VER_IHL;
            4'd1:    csum_word = tot_q;
            4'd2:    csum_word = ip_id_q;
            4'd3:    csum_word = IP_FLAGS_DF;
            4'd4:    csum_word = {cfg_ttl, IP_PROTO_UDP};
            4'd5:    csum_word = cfg_ip_src[31:16];
            4'd6:    csum_word = cfg_ip_src[15:0];
            4'd7:    csum_word = cfg_ip_dst[31:16];
            default: csum_word = cfg_ip_dst[15:0];
        endcase
    end

`ifdef UDP_TX_WATCHDOG_EN
    logic [15:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = '0;
        if (state_q == ST_SEND && !tx_data_in_rd && !tx_eop) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    assign wdog_fire = (state_q == ST_SEND) && !tx_data_in_rd && !tx_eop &&
                       (wdog_q == 16'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES != 0);
    assign wdog_fire   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        k_d     = k_q;
        grant_d = grant_q;
        sport_d = sport_q;
        dport_d = dport_q;
        len_d   = len_q;
        tot_d   = tot_q;
        ip_id_d = ip_id_q;
        chk_d   = chk_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        err     = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (!arb_vld) begin
                    state_d = ST_IDLE;
                end else if (len_a[arb_idx] > 16'(MAX_PAYLOAD)) begin
                    err     = arb_gnt;
                    ptr_d   = ptr_next(arb_idx);
                    state_d = ST_IDLE;
                end else begin
                    k_d     = arb_idx;
                    grant_d = arb_gnt;
                    sport_d = sport_a[arb_idx];
                    dport_d = dport_a[arb_idx];
                    len_d   = len_a[arb_idx];
                    tot_d   = len_a[arb_idx] + IP_UDP_OVERHEAD;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                sum_d = sum_q + {4'b0, csum_word};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(CSUM_WORDS - 1)) begin
                    chk_d   = ~csum_fold(sum_d);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_eop) begin
                    state_d = ST_FIN;
                end else if (wdog_fire) begin
                    err     = grant_q;
                    ptr_d   = ptr_next(k_q);
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_FIN: begin
                ip_id_d = ip_id_q + 16'd1;
                ptr_d   = ptr_next(k_q);
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            k_q     <= '0;
            grant_q <= '0;
            sport_q <= '0;
            dport_q <= '0;
            len_q   <= '0;
            tot_q   <= '0;
            ip_id_q <= '0;
            chk_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            k_q     <= k_d;
            grant_q <= grant_d;
            sport_q <= sport_d;
            dport_q <= dport_d;
            len_q   <= len_d;
            tot_q   <= tot_d;
            ip_id_q <= ip_id_d;
            chk_q   <= chk_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant              = grant_q;
    assign done               = (state_q == ST_FIN) ? grant_q : '0;
    assign ch_data_rd         = (state_q == ST_SEND && tx_data_in_rd) ? grant_q : '0;
    assign tx_data_in         = (state_q == ST_SEND) ? data_a[k_q] : '0;
    assign tx_start           = (state_q == ST_START);
    assign tx_udp_src_port    = sport_q;
    assign tx_udp_dst_port    = dport_q;
    assign tx_udp_data_length = len_q;
    assign tx_ip_total_len    = tot_q;
    assign tx_ip_id           = ip_id_q;
    assign tx_ip_head_chksum  = chk_q;
    assign tx_abort           = wdog_fire;
    assign busy               = (state_q != ST_IDLE);

endmodule
